// File: rtl/alu_pkg.sv
// Shared op-code encodings, engine state type and default width for the ALU / MDU slice.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [3:0] ALU_ADDU  = 4'd0;
  localparam logic [3:0] ALU_SUBU  = 4'd1;
  localparam logic [3:0] ALU_OR    = 4'd2;
  localparam logic [3:0] ALU_LUI   = 4'd3;
  localparam logic [3:0] ALU_AND   = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_NOR   = 4'd6;
  localparam logic [3:0] ALU_SLT   = 4'd7;
  localparam logic [3:0] ALU_SLTU  = 4'd8;
  localparam logic [3:0] ALU_MFHI  = 4'd9;
  localparam logic [3:0] ALU_MFLO  = 4'd10;
  localparam logic [3:0] ALU_MULTU = 4'd11;
  localparam logic [3:0] ALU_MULT  = 4'd12;
  localparam logic [3:0] ALU_DIVU  = 4'd13;
  localparam logic [3:0] ALU_DIV   = 4'd14;
  localparam logic [3:0] ALU_MT    = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } md_state_e;

endpackage

// File: rtl/alu_md_iter.sv
// Iterative multiply/divide engine: WIDTH shift-add or restoring-divide steps, then one sign-fix cycle.
// The divider datapath exists only when ALU_MDU_DIV_EN is defined.
module alu_md_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done_commit,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               negP_q, negP_d;

  logic [WIDTH-1:0]   aMag, bMag;
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulStep, prodFix;

  // Both ops run on magnitudes; acc holds {partial, multiplier/dividend}.
  assign aMag = (is_signed && a[WIDTH-1]) ? -a : a;
  assign bMag = (is_signed && b[WIDTH-1]) ? -b : b;

  assign mulSum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
  assign mulStep = {mulSum, acc_q[WIDTH-1:1]};
  assign prodFix = negP_q ? -acc_q : acc_q;

`ifdef ALU_MDU_DIV_EN
  logic             div_q, div_d;
  logic             dz_q, dz_d;
  logic             negR_q, negR_d;
  logic [WIDTH:0]   remShift, remDiff;
  logic [2*WIDTH-1:0] divStep;
  logic [WIDTH-1:0] quotRaw, remRaw;

  // remDiff[WIDTH] is the borrow: set means the divisor did not fit this step.
  assign remShift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign remDiff  = remShift - {1'b0, opnd_q};
  assign divStep  = remDiff[WIDTH] ? {remShift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                   : {remDiff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
  assign quotRaw  = acc_q[WIDTH-1:0];
  assign remRaw   = acc_q[2*WIDTH-1:WIDTH];

  // A zero divisor leaves |a| as remainder, so only the quotient needs forcing.
  always_comb begin
    res_hi = prodFix[2*WIDTH-1:WIDTH];
    res_lo = prodFix[WIDTH-1:0];
    if (div_q) begin
      res_hi = negR_q ? -remRaw : remRaw;
      res_lo = dz_q ? {WIDTH{1'b1}} : (negP_q ? -quotRaw : quotRaw);
    end
  end
`else
  logic unused_div;
  assign unused_div = is_div;

  always_comb begin
    res_hi = prodFix[2*WIDTH-1:WIDTH];
    res_lo = prodFix[WIDTH-1:0];
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    negP_d  = negP_q;
`ifdef ALU_MDU_DIV_EN
    div_d   = div_q;
    dz_d    = dz_q;
    negR_d  = negR_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          acc_d   = {{WIDTH{1'b0}}, aMag};
          opnd_d  = bMag;
          negP_d  = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef ALU_MDU_DIV_EN
          div_d   = is_div;
          dz_d    = (b == '0);
          negR_d  = is_signed && a[WIDTH-1];
`endif
        end
      end
      S_RUN: begin
`ifdef ALU_MDU_DIV_EN
        acc_d = div_q ? divStep : mulStep;
`else
        acc_d = mulStep;
`endif
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      negP_q  <= 1'b0;
`ifdef ALU_MDU_DIV_EN
      div_q   <= 1'b0;
      dz_q    <= 1'b0;
      negR_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      negP_q  <= negP_d;
`ifdef ALU_MDU_DIV_EN
      div_q   <= div_d;
      dz_q    <= dz_d;
      negR_q  <= negR_d;
`endif
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done_commit = (state_q == S_FIX);

endmodule

// File: rtl/alu_mdu.sv
// EX-stage ALU with HI/LO registers and an iterative MULT/DIV engine behind start/busy/done.
// Divide support is compiled in with ALU_MDU_DIV_EN; otherwise DIV/DIVU launch as 1-cycle no-ops.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             start,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;
  logic             engBusy, engCommit, engStart;
  logic             launch, isMul, isDiv, isSigned;
  logic [WIDTH-1:0] engHi, engLo, aluRes;

  assign isMul    = (op == ALU_MULTU) || (op == ALU_MULT);
  assign isDiv    = (op == ALU_DIVU)  || (op == ALU_DIV);
  assign isSigned = (op == ALU_MULT)  || (op == ALU_DIV);
  assign launch   = start && !engBusy && (op >= ALU_MULTU);

`ifdef ALU_MDU_DIV_EN
  assign engStart = launch && (isMul || isDiv);
`else
  assign engStart = launch && isMul;
`endif

  alu_md_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (engStart),
    .is_div      (isDiv),
    .is_signed   (isSigned),
    .a           (a),
    .b           (b),
    .busy        (engBusy),
    .done_commit (engCommit),
    .res_hi      (engHi),
    .res_lo      (engLo)
  );

  // Launches the engine does not take (MT*, disabled DIV) complete on their own edge.
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = engCommit || (launch && !engStart);
    if (engCommit) begin
      hi_d = engHi;
      lo_d = engLo;
    end else if (launch && (op == ALU_MT)) begin
      if (b[0]) hi_d = a;
      else      lo_d = a;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    aluRes = '0;
    case (op)
      ALU_ADDU: aluRes = a + b;
      ALU_SUBU: aluRes = a - b;
      ALU_OR:   aluRes = a | b;
      ALU_LUI:  aluRes = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      ALU_AND:  aluRes = a & b;
      ALU_XOR:  aluRes = a ^ b;
      ALU_NOR:  aluRes = ~(a | b);
      ALU_SLT:  aluRes = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: aluRes = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_MFHI: aluRes = hi_q;
      ALU_MFLO: aluRes = lo_q;
      default:  aluRes = '0;
    endcase
  end

  assign out  = aluRes;
  assign zero = (aluRes == '0);
  assign busy = engBusy;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu: combinational ops checked directly, HI/LO results through a scoreboard queue.
// Expectations for DIV/DIVU follow ALU_MDU_DIV_EN so the same bench covers both builds.
module tb_alu_mdu;
  import alu_pkg::*;

  localparam int W = 32;
`ifdef ALU_MDU_DIV_EN
  localparam int DIV_BUSY = W + 1;
`else
  localparam int DIV_BUSY = 0;
`endif

  typedef struct {
    string          tag;
    logic [W-1:0]   hi;
    logic [W-1:0]   lo;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a, b, out, hi, lo;
  logic [3:0]   op;
  logic         start, zero, busy, done;

  exp_t         sb[$];
  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] modelHi, modelLo;

  always #5 clk = ~clk;

  alu_mdu #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .op    (op),
    .start (start),
    .out   (out),
    .zero  (zero),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                               input logic st);
    @(negedge clk);
    op = o; a = va; b = vb; start = st;
  endtask

  task automatic expectCommit(input string tag, input logic [W-1:0] eh, input logic [W-1:0] el);
    exp_t e;
    e.tag = tag; e.hi = eh; e.lo = el;
    sb.push_back(e);
    modelHi = eh;
    modelLo = el;
  endtask

  task automatic launchOp(input logic [3:0] o, input logic [W-1:0] va, input logic [W-1:0] vb);
    applyStimulus(o, va, vb, 1'b1);
    @(negedge clk);
    start = 1'b0;
    op    = ALU_ADDU;
  endtask

  // Counts busy cycles from the current negedge, then pops and compares the committed HI/LO.
  task automatic waitCommit(input string tag, input int expBusy);
    int   n;
    exp_t e;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    checkOutput({tag, " busy cycles"}, W'(n), W'(expBusy));
    checkOutput({tag, " done"}, W'(done), W'(1));
    checkOutput({tag, " sb nonempty"}, W'(sb.size() > 0), W'(1));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput({e.tag, " hi"}, hi, e.hi);
      checkOutput({e.tag, " lo"}, lo, e.lo);
    end
    @(negedge clk);
    checkOutput({tag, " done pulse end"}, W'(done), W'(0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0; a = '0; b = '0; op = ALU_ADDU; start = 1'b0;
    modelHi = '0; modelLo = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset hi", hi, '0);
    checkOutput("reset lo", lo, '0);
    checkOutput("reset busy", W'(busy), W'(0));
    checkOutput("reset done", W'(done), W'(0));
    rst_n = 1'b1;

    applyStimulus(ALU_ADDU, 32'hFFFF_FFFF, 32'd1, 1'b0); #1;
    checkOutput("addu wrap out", out, 32'h0);
    checkOutput("addu wrap zero", W'(zero), W'(1));
    applyStimulus(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 1'b0); #1;
    checkOutput("slt", out, 32'd1);
    applyStimulus(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 1'b0); #1;
    checkOutput("sltu", out, 32'd0);
    applyStimulus(ALU_SUBU, 32'd5, 32'd7, 1'b0); #1;
    checkOutput("subu wrap", out, 32'hFFFF_FFFE);
    checkOutput("subu zero", W'(zero), W'(0));
    applyStimulus(ALU_LUI, 32'hDEAD_1234, 32'hBEEF_ABCD, 1'b0); #1;
    checkOutput("lui", out, 32'hABCD_0000);
    applyStimulus(ALU_NOR, 32'h0F0F_0000, 32'h0000_00F0, 1'b0); #1;
    checkOutput("nor", out, 32'hF0F0_FF0F);
    applyStimulus(ALU_XOR, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0); #1;
    checkOutput("xor", out, 32'hF0F0_F0F0);
    applyStimulus(ALU_MULT, 32'd3, 32'd4, 1'b0); #1;
    checkOutput("mult op comb out", out, 32'h0);

    expectCommit("mult -3*7", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    launchOp(ALU_MULT, 32'hFFFF_FFFD, 32'd7);
    waitCommit("mult -3*7", W + 1);
    applyStimulus(ALU_MFHI, '0, '0, 1'b0); #1;
    checkOutput("mfhi", out, 32'hFFFF_FFFF);
    applyStimulus(ALU_MFLO, '0, '0, 1'b0); #1;
    checkOutput("mflo", out, 32'hFFFF_FFEB);

    expectCommit("multu max*max", 32'hFFFF_FFFE, 32'h0000_0001);
    launchOp(ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (4) @(negedge clk);
    applyStimulus(ALU_MULT, 32'd2, 32'd3, 1'b1);
    applyStimulus(ALU_MFLO, '0, '0, 1'b0); #1;
    checkOutput("mflo while busy", out, 32'hFFFF_FFEB);
    waitCommit("multu second start", W + 1 - 6);

`ifdef ALU_MDU_DIV_EN
    expectCommit("div -7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
`else
    expectCommit("div -7/2", modelHi, modelLo);
`endif
    launchOp(ALU_DIV, 32'hFFFF_FFF9, 32'd2);
    waitCommit("div -7/2", DIV_BUSY);

`ifdef ALU_MDU_DIV_EN
    expectCommit("div 7/-2", 32'd1, 32'hFFFF_FFFD);
    launchOp(ALU_DIV, 32'd7, 32'hFFFF_FFFE);
    waitCommit("div 7/-2", DIV_BUSY);
    expectCommit("div minneg/-1", 32'd0, 32'h8000_0000);
    launchOp(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    waitCommit("div minneg/-1", DIV_BUSY);
    expectCommit("div -9/0", 32'hFFFF_FFF7, 32'hFFFF_FFFF);
    launchOp(ALU_DIV, 32'hFFFF_FFF7, 32'd0);
    waitCommit("div -9/0", DIV_BUSY);
    expectCommit("divu 100/0", 32'd100, 32'hFFFF_FFFF);
`else
    expectCommit("divu 100/0", modelHi, modelLo);
`endif
    launchOp(ALU_DIVU, 32'd100, 32'd0);
    waitCommit("divu 100/0", DIV_BUSY);

    applyStimulus(ALU_ADDU, 32'd1, 32'd2, 1'b1);
    applyStimulus(ALU_ADDU, 32'd1, 32'd2, 1'b0); #1;
    checkOutput("start addu busy", W'(busy), W'(0));
    checkOutput("start addu done", W'(done), W'(0));
    checkOutput("start addu hi", hi, modelHi);

    expectCommit("mthi", 32'd5, modelLo);
    launchOp(ALU_MT, 32'd5, 32'd1);
    waitCommit("mthi", 0);
    expectCommit("mtlo", 32'd5, 32'd9);
    launchOp(ALU_MT, 32'd9, 32'd0);
    waitCommit("mtlo", 0);

`ifdef ALU_MDU_DIV_EN
    launchOp(ALU_DIVU, 32'd1000, 32'd7);
`else
    launchOp(ALU_MULTU, 32'd1000, 32'd7);
`endif
    repeat (9) @(negedge clk);
    rst_n = 1'b0; #1;
    checkOutput("midop reset busy", W'(busy), W'(0));
    checkOutput("midop reset hi", hi, '0);
    checkOutput("midop reset lo", lo, '0);
    @(negedge clk);
    rst_n = 1'b1;

    expectCommit("multu 5*6", 32'd0, 32'd30);
    launchOp(ALU_MULTU, 32'd5, 32'd6);
    waitCommit("multu 5*6", W + 1);

    checkOutput("scoreboard drained", W'(sb.size()), W'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
